// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel switch debouncer.
// Holds the auto-repeat state encoding and the counter-width helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } rpt_state_t;

  // max(1, clog2(n)): a counter that must hold 0..n-1, never narrower than 1 bit
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced channel: two-flop synchroniser, tick-gated stability counter,
// and an auto-repeat FSM. All outputs are registered.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT   = 10,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       din,
  output logic       level,
  output logic       press,
  output logic       rel,
  output logic       rpt,
  output rpt_state_t state
);

  localparam int CW   = cnt_width(STABLE_CNT);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = cnt_width(RMAX + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_CNT - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RATE_LAST  = RW'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);
  localparam bit            REPEAT_EN  = (REPEAT_DELAY > 0);

  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic          accept, acc_press, acc_release;

  rpt_state_t    state_n;
  logic [RW-1:0] rc, rc_n;
  logic          rpt_n;

  // Synchroniser runs every clk so a slow tick never adds metastability risk
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  assign accept      = tick && (s2 != level) && (cnt == CNT_LAST);
  assign acc_press   = accept && s2;
  assign acc_release = accept && !s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (tick) begin
        if (s2 == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          level <= s2;
          cnt   <= '0;
          press <= s2;
          rel   <= !s2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Release has priority over a repeat that would fire on the same tick
  always_comb begin
    state_n = state;
    rc_n    = rc;
    rpt_n   = 1'b0;
    if (REPEAT_EN && tick) begin
      case (state)
        IDLE: begin
          if (acc_press) begin
            state_n = HELD;
            rc_n    = '0;
          end
        end
        HELD: begin
          if (acc_release) begin
            state_n = IDLE;
            rc_n    = '0;
          end else if (rc == DELAY_LAST) begin
            rpt_n   = 1'b1;
            rc_n    = '0;
            state_n = REPEATING;
          end else begin
            rc_n = rc + RW'(1);
          end
        end
        REPEATING: begin
          if (acc_release) begin
            state_n = IDLE;
            rc_n    = '0;
          end else if (rc == RATE_LAST) begin
            rpt_n = 1'b1;
            rc_n  = '0;
          end else begin
            rc_n = rc + RW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          rc_n    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rc    <= '0;
      rpt   <= 1'b0;
    end else begin
      state <= state_n;
      rc    <= rc_n;
      rpt   <= rpt_n;
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: CHANNELS independent copies of debounce_chan.
// dbg_state exposes each channel's repeat FSM state, two bits per channel.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int STABLE_CNT   = 10,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [CHANNELS-1:0]   Din,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   press,
  output logic [CHANNELS-1:0]   rel,
  output logic [CHANNELS-1:0]   rpt,
  output logic [2*CHANNELS-1:0] dbg_state
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("debounce_multi: CHANNELS must be at least 1");
  end
  if (STABLE_CNT < 2) begin : g_bad_stable
    $error("debounce_multi: STABLE_CNT must be at least 2");
  end
  if (REPEAT_RATE < 1) begin : g_bad_rate
    $error("debounce_multi: REPEAT_RATE must be at least 1");
  end
  if (REPEAT_DELAY < 0) begin : g_bad_delay
    $error("debounce_multi: REPEAT_DELAY must not be negative");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    rpt_state_t st;

    debounce_chan #(
      .STABLE_CNT   (STABLE_CNT),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .din   (Din[i]),
      .level (level[i]),
      .press (press[i]),
      .rel   (rel[i]),
      .rpt   (rpt[i]),
      .state (st)
    );

    assign dbg_state[2*i +: 2] = st;
  end

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel switch debouncer for pushbutton and slide-switch inputs. Provides one-shot pulses on press and release, and an optional auto-repeat pulse while a button is held. Runs on the system clock and samples on a `tick` strobe rather than on a divided clock. Sits between the board pins and the control/FSM logic, and is the successor of the single-channel shift-register debouncer.

## Interface
- `CHANNELS`, 4 — number of independent inputs; ≥1
- `STABLE_CNT`, 10 — consecutive differing samples required to accept a new level; ≥2
- `REPEAT_DELAY`, 0 — ticks held before the first repeat pulse; 0 disables repeat entirely
- `REPEAT_RATE`, 25 — ticks between subsequent repeat pulses; ≥1; ignored when `REPEAT_DELAY`=0

Ports:
- `clk` in 1 — system clock; single clock domain
- `reset` in 1 — synchronous, active-high
- `tick` in 1 — sample-enable strobe, one `clk` wide (e.g. 500 Hz divider output); tie high to sample every cycle
- `Din` in CHANNELS — raw asynchronous switch inputs
- `level` out CHANNELS — debounced level
- `press` out CHANNELS — one-`clk` pulse on accepted 0→1
- `release` out CHANNELS — one-`clk` pulse on accepted 1→0
- `rpt` out CHANNELS — one-`clk` auto-repeat pulse

## Operation
- Channels are fully independent; the description below is per channel.
- Synchroniser: two flops on `Din`, clocked every `clk` and not gated by `tick`; output `s`.
- Stability counter `cnt`, width max(1, clog2(STABLE_CNT)), advances only on `tick` cycles:
  - `s` == `level`: `cnt` ← 0 (a bounce restarts the count).
  - `s` != `level` and `cnt` < STABLE_CNT−1: `cnt` += 1.
  - `s` != `level` and `cnt` == STABLE_CNT−1: `level` ← `s`, `cnt` ← 0, and `press` or `release` is asserted for the following cycle.
- Repeat FSM, repeat counter `rc`, width clog2(max(REPEAT_DELAY, REPEAT_RATE)+1); `rc` advances on `tick` only:
  - IDLE (`level`=0): on accepted press → HELD, `rc` ← 0.
  - HELD: `rc` == REPEAT_DELAY−1 → pulse `rpt`, `rc` ← 0, go to REPEATING. Otherwise `rc` += 1.
  - REPEATING: `rc` == REPEAT_RATE−1 → pulse `rpt`, `rc` ← 0. Otherwise `rc` += 1.
  - From HELD or REPEATING, an accepted release → IDLE, `rc` ← 0.
  - When `REPEAT_DELAY`=0, the FSM is held in IDLE and `rpt` is constant 0.
- The press tick does not count toward `REPEAT_DELAY`; counting starts on the next tick.
- If a release is accepted on the tick where `rpt` would fire, release wins and no `rpt` is issued.
- When `tick`=0, all state holds except the synchroniser, and no pulses are generated.

## Timing
- Reset values: `level`, `press`, `release`, `rpt`, `cnt`, `rc`, and the synchroniser flops are all 0; FSM is IDLE.
- Reset asserted mid-count or mid-hold clears everything.
- No pulse is emitted in the cycle after `reset` deasserts, even if `Din`=1. A held input is accepted STABLE_CNT ticks after the synchroniser fills.
- All outputs are registered.
- Latency with `tick` tied high: `Din` changes before edge 1 → `s` valid after edge 2 → `level` and `press` change after edge STABLE_CNT+2 (12 with defaults).
- Latency with a periodic `tick`: accepted after STABLE_CNT ticks that sample the new `s`, plus up to 2 `clk` of synchroniser delay.
- `press`, `release`, and `rpt` are exactly one `clk` wide regardless of the `tick` period.
- `level` and the press/release pulse assert on the same edge.
- First `rpt` comes REPEAT_DELAY ticks after the press tick; subsequent pulses every REPEAT_RATE ticks.

## Structure
- Shared package `debounce_pkg`:
  - Repeat FSM state enum (IDLE, HELD, REPEATING)
  - Counter-width helper function implementing max(1, clog2(n))
- Sub-module `debounce_chan`: one channel, containing the synchroniser, stability counter, and repeat FSM.
- `debounce_multi` is a generate loop instantiating CHANNELS copies of `debounce_chan`, plus parameter legality checks (elaboration-time error on STABLE_CNT<2 or REPEAT_RATE=0).

## Test plan
- Clean press, defaults, `tick` high: `Din[0]` 0→1 before edge 1 → `level[0]`=1 and `press[0]`=1 for one cycle after edge 12; `release`, `rpt`, and other channels stay 0.
- Bounce: `Din[1]` pattern 1,1,1,0,1×10 (one per tick) → the 0 resets `cnt`; `press[1]` fires after the 10th consecutive 1 (plus 2-cycle sync); exactly one pulse.
- Release plus periodic `tick` (1 in 8): held channel drops → `release` pulses one `clk` after the 10th low-sampling tick; `level`=0; no second pulse while `tick`=0.
- Auto-repeat, REPEAT_DELAY=4, REPEAT_RATE=2, `tick` high: hold `Din[2]` → `rpt[2]` 4 ticks after `press`, then every 2 ticks; release on a repeat tick → `release` only, no `rpt`.
- Reset mid-operation: assert `reset` for 1 cycle while channel 3 is in REPEATING with `cnt`=5 → next cycle all outputs 0; with `Din[3]` still 1, `press[3]` re-fires 12 cycles after reset deasserts.
- Repeat disabled (REPEAT_DELAY=0): hold input 1000 cycles → `rpt` never asserts.
